// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and the iteration counter sizing helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Counter must hold 0..WIDTH-1.
  function automatic int mdu_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore result signs; -MIN maps onto itself, which is its magnitude.
module mdu_signfix #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers. One multiplier or
// quotient bit per cycle on magnitudes; signs are reapplied in the FIX state.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CW   = mdu_cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mdu_state_e state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // mult: {partial product, multiplier}; div: quotient in low half
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   opd;   // multiplicand or divisor magnitude
  logic               is_div, neg_q, neg_r, dz;

  // Operand decode and magnitudes
  logic             op_signed, op_div, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign op_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign sa        = op_signed & a[WIDTH-1];
  assign sb        = op_signed & b[WIDTH-1];

  mdu_signfix #(.WIDTH(WIDTH)) u_abs_a (.neg(sa), .din(a), .dout(abs_a));
  mdu_signfix #(.WIDTH(WIDTH)) u_abs_b (.neg(sb), .din(b), .dout(abs_b));

  // Shift-add step
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_nxt;
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_nxt = {sum, acc[WIDTH-1:1]};

  // Restoring divide step; diff[WIDTH] set means the trial subtraction borrowed
  logic [WIDTH:0] trial, diff;
  assign trial = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign diff  = trial - {1'b0, opd};

  // Result sign correction
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  mdu_signfix #(.WIDTH(2*WIDTH)) u_fix_p (.neg(neg_q), .din(acc),                .dout(prod_fix));
  mdu_signfix #(.WIDTH(WIDTH))   u_fix_q (.neg(neg_q), .din(acc[WIDTH-1:0]),     .dout(q_fix));
  mdu_signfix #(.WIDTH(WIDTH))   u_fix_r (.neg(neg_r), .din(rem[WIDTH-1:0]),     .dout(r_fix));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      opd      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          // MTHI/MTLO land first; an op started this cycle overwrites them at FIX
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            is_div   <= op_div;
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            dz       <= op_div && (b == '0);
            opd      <= op_div ? abs_b : abs_a;
            acc      <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            rem <= diff[WIDTH] ? trial : diff;
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            acc <= mul_nxt;
          end
        end
        FIX: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= dz;
          if (is_div) begin
            // Divide by zero leaves rem = |a|, so r_fix restores the original dividend
            lo <= dz ? '1 : q_fix;
            hi <= r_fix;
          end else begin
            lo <= prod_fix[WIDTH-1:0];
            hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench: drivers push expected HI/LO/div_zero per op, monitors pop on done.
// WIDTH=32 directed vectors plus a WIDTH=8 sweep against an integer reference.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, hi_we, lo_we, busy, done, div_zero;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;

  logic        rst8_n, start8, hi_we8, lo_we8, busy8, done8, div_zero8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8, hi8, lo8;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       tag;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst_n && done === 1'b1) begin
      if (q32.size() == 0) check("w32 unexpected done", 32'(done), 32'd0);
      else begin
        e = q32.pop_front();
        check({e.tag, " hi"}, hi, e.hi);
        check({e.tag, " lo"}, lo, e.lo);
        check({e.tag, " div_zero"}, 32'(div_zero), 32'(e.dz));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst8_n && done8 === 1'b1) begin
      if (q8.size() == 0) check("w8 unexpected done", 32'(done8), 32'd0);
      else begin
        e = q8.pop_front();
        check({e.tag, " hi"}, 32'(hi8), e.hi);
        check({e.tag, " lo"}, 32'(lo8), e.lo);
        check({e.tag, " div_zero"}, 32'(div_zero8), 32'(e.dz));
      end
    end
  end

  // Issue at a negedge with the unit idle; returns at the done negedge so the
  // next call starts back-to-back.
  task automatic op32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                      input string tag);
    int k;
    q32.push_back('{ehi, elo, edz, tag});
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    check({tag, " div_zero cleared"}, 32'(div_zero), 32'd0);
    k = 1;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k - 1), 32'd33);
    check({tag, " busy low at done"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_idle32(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, " idle wait"}, 32'(busy), 32'd0);
  endtask

  task automatic op8_run(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int          sx, sy, p, qq, rr, k;
    logic [31:0] eh, el;
    logic        ed, sgn;
    string       tag;
    sgn = (o == MDU_MULT) || (o == MDU_DIV);
    sx  = sgn ? int'($signed(x)) : int'(x);
    sy  = sgn ? int'($signed(y)) : int'(y);
    ed  = 1'b0;
    if (o == MDU_MULT || o == MDU_MULTU) begin
      p  = sx * sy;
      eh = {24'b0, p[15:8]};
      el = {24'b0, p[7:0]};
    end else if (y == 8'd0) begin
      eh = {24'b0, x};
      el = 32'h0000_00FF;
      ed = 1'b1;
    end else begin
      qq = sx / sy;
      rr = sx % sy;
      eh = {24'b0, rr[7:0]};
      el = {24'b0, qq[7:0]};
    end
    tag = $sformatf("w8 op%0d %02h,%02h", o, x, y);
    q8.push_back('{eh, el, ed, tag});
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 1;
    while (done8 !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k - 1), 32'd9);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          nd;
    logic [7:0]  vals [12];
    vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h10,
             8'h3F, 8'h64, 8'h7F, 8'h80, 8'hC8, 8'hFF};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    rst8_n = 1'b0; start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    hi_we8 = 1'b0; lo_we8 = 1'b0; wdata8 = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    rst_n = 1'b1; rst8_n = 1'b1;
    @(negedge clk);

    // MTHI/MTLO while idle
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt both hi", hi, 32'h1234_5678);
    check("mt both lo", lo, 32'h1234_5678);
    hi_we = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi only hi", hi, 32'hCAFE_0001);
    check("mthi only lo", lo, 32'h1234_5678);

    // Directed ops, issued back-to-back
    op32(MDU_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult 7*-3");
    op32(MDU_MULTU, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0, "multu 7*fffffffd");
    op32(MDU_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, "divu 100/7");
    op32(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div -7/2");
    op32(MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div 7/-2");
    op32(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div min/-1");
    op32(MDU_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1, "divu 5/0");
    op32(MDU_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div -5/0");
    op32(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult min*min");
    op32(MDU_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "mult min*-1");
    op32(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu max*max");

    // MTHI in the same cycle as start: write lands, result overwrites later
    q32.push_back('{32'h0, 32'h0000_002A, 1'b0, "mt+start multu 6*7"});
    op = MDU_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("mt+start hi written", hi, 32'hAAAA_5555);
    wait_idle32("mt+start");

    // start pulses and MTHI/MTLO while busy are dropped
    q32.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "busy-ignore mult"});
    op = MDU_MULT; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = MDU_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("busy mt dropped hi", hi, 32'h0000_0000);
    check("busy mt dropped lo", lo, 32'h0000_002A);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("busy-ignore done count", 32'(nd), 32'd1);

    // Asynchronous reset mid-op
    op = MDU_MULT; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst hi", hi, 32'd0);
    check("async rst lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("no done after reset", 32'(nd), 32'd0);
    check("w32 queue drained", 32'(q32.size()), 32'd0);

    // WIDTH=8 sweep, all four ops, against integer reference arithmetic
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 12; i++)
        for (int j = 0; j < 12; j++)
          op8_run(2'(o), vals[i], vals[j]);
    repeat (3) @(negedge clk);
    check("w8 queue drained", 32'(q8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
